// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control path: FSM states, opcodes,
// PC next-value select and write-back select.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JAL    = 2'b10,
        PC_JALR   = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic legal;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_jal;
        logic is_jalr;
        logic is_fence;
    } op_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier. SYSTEM and anything unlisted come out with legal=0.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_R, OP_IMM, OP_LUI, OP_AUIPC: cls.legal = 1'b1;
            OP_LOAD:   begin cls.legal = 1'b1; cls.is_load   = 1'b1; end
            OP_STORE:  begin cls.legal = 1'b1; cls.is_store  = 1'b1; end
            OP_BRANCH: begin cls.legal = 1'b1; cls.is_branch = 1'b1; end
            OP_JAL:    begin cls.legal = 1'b1; cls.is_jal    = 1'b1; end
            OP_JALR:   begin cls.legal = 1'b1; cls.is_jalr   = 1'b1; end
            OP_FENCE:  begin cls.legal = 1'b1; cls.is_fence  = 1'b1; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory-wait
// timeout and an absorbing FAULT state.
module control_fsm
    import ctrl_pkg::*;
#(
    parameter int TMO_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pcsrc,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic [2:0] state,
    output logic       fault
);

    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
    logic             tmo_expired;
    op_class_t        cls;

    ctrl_decode u_decode (
        .opcode (opcode),
        .cls    (cls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    // A wait cycle that would push the counter to all-ones faults instead,
    // so at most 2^TMO_W-1 request cycles are spent per transfer.
    assign tmo_inc     = tmo_q + TMO_W'(1);
    assign tmo_expired = (tmo_inc == TMO_MAX);

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pcsrc     = PC_PLUS4;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (tmo_expired) begin
                    state_d = S_FAULT;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_DECODE: state_d = cls.legal ? S_EXEC : S_FAULT;
            S_EXEC: begin
                if (!cls.legal) begin
                    state_d = S_FAULT;
                end else if (cls.is_branch || cls.is_fence) begin
                    pc_write = 1'b1;
                    pcsrc    = (cls.is_branch && branch_taken) ? PC_BRANCH : PC_PLUS4;
                    state_d  = S_FETCH;
                end else if (cls.is_load || cls.is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = cls.is_store;
                if (mem_ready) begin
                    pc_write = cls.is_store;
                    state_d  = cls.is_store ? S_FETCH : S_WB;
                end else if (tmo_expired) begin
                    state_d = S_FAULT;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                wb_sel    = cls.is_load ? WB_MEM :
                            (cls.is_jal || cls.is_jalr) ? WB_PC4 : WB_ALU;
                pcsrc     = cls.is_jal ? PC_JAL : cls.is_jalr ? PC_JALR : PC_PLUS4;
                state_d   = S_FETCH;
            end
            S_FAULT: ;
            default: state_d = S_FAULT;
        endcase

        if (state_d != state_q) tmo_d = '0;

        // Reset drops every request/enable at once, abandoning any write.
        if (!rst_n) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign state = state_q;
    assign fault = (state_q == S_FAULT);

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL have parameter TMO_W, default 4, the width of the memory-wait timeout counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port opcode, input, 7 bits: instruction bits [6:0] from the instruction register.
REQ-005 The block SHALL have port branch_taken, input, 1 bit: the branch comparator result, valid in EXEC.
REQ-006 The block SHALL have port mem_ready, input, 1 bit: the memory completes the current request.
REQ-007 The block SHALL have port mem_req, output, 1 bit: memory request.
REQ-008 The block SHALL have port mem_we, output, 1 bit: write request; valid only while mem_req=1.
REQ-009 The block SHALL have port addr_sel, output, 1 bit: memory address source, 0=PC, 1=ALU result.
REQ-010 The block SHALL have port ir_write, output, 1 bit: load the instruction register.
REQ-011 The block SHALL have port pc_write, output, 1 bit: load the PC from the PC next-value mux.
REQ-012 The block SHALL have port pcsrc, output, 2 bits: mux select; 00=pc+4, 01=branch target, 10=JAL target, 11=JALR ALU result.
REQ-013 The block SHALL have port reg_write, output, 1 bit: register-file write enable.
REQ-014 The block SHALL have port wb_sel, output, 2 bits: write-back source; 00=ALU, 01=memory data, 10=pc+4.
REQ-015 The block SHALL have port state, output, 3 bits: current state encoding, for debug.
REQ-016 The block SHALL have port fault, output, 1 bit: sticky fault flag.

Function
REQ-017 The block SHALL implement the states FETCH, DECODE, EXEC, MEM, WB and FAULT, with one registered state variable.
REQ-018 In FETCH the block SHALL assert mem_req=1, mem_we=0 and addr_sel=0.
REQ-019 In FETCH, when mem_ready=1, the block SHALL assert ir_write=1 in that same cycle and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-020 DECODE SHALL last one cycle: a legal opcode goes to EXEC; an illegal opcode, or SYSTEM (1110011), goes to FAULT.
REQ-021 The legal opcodes SHALL be R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC and FENCE.
REQ-022 In EXEC, BRANCH SHALL assert pc_write=1 with pcsrc=01 if branch_taken=1, or pcsrc=00 if branch_taken=0, and go to FETCH.
REQ-023 In EXEC, FENCE SHALL assert pc_write=1 with pcsrc=00 and go to FETCH.
REQ-024 From EXEC, LOAD and STORE SHALL go to MEM; all other legal opcodes SHALL go to WB.
REQ-025 In MEM the block SHALL assert mem_req=1 and addr_sel=1, with mem_we=1 for STORE.
REQ-026 On mem_ready=1 in MEM, a STORE SHALL assert pc_write=1 with pcsrc=00 in that cycle and go to FETCH; a LOAD SHALL go to WB.
REQ-027 WB SHALL last one cycle, asserting reg_write=1 and pc_write=1, then go to FETCH.
REQ-028 In WB, wb_sel SHALL be 01 for LOAD, 10 for JAL and JALR, and 00 otherwise.
REQ-029 In WB, pcsrc SHALL be 10 for JAL, 11 for JALR, and 00 otherwise.
REQ-030 Handshake: mem_req SHALL stay high, with mem_we and addr_sel stable, until the cycle in which mem_ready=1 is sampled; mem_ready outside FETCH/MEM SHALL be ignored.
REQ-031 Timeout: a TMO_W-bit counter SHALL clear on entry to FETCH or MEM and increment each waiting cycle.
REQ-032 If the timeout counter reaches 2^TMO_W-1 with mem_ready=0, the block SHALL go to FAULT.
REQ-033 If mem_ready=1 arrives in the same cycle the timeout counter saturates, the block SHALL complete the transfer normally rather than fault.
REQ-034 FAULT SHALL be absorbing: fault=1, and all enables (mem_req, ir_write, pc_write, reg_write) SHALL be 0 until reset.
REQ-035 Cycle counts with zero-wait memory SHALL be: BRANCH/FENCE 3; ALU/LUI/AUIPC/JAL/JALR 4; STORE 4; LOAD 5.
REQ-036 pc_write SHALL be asserted exactly once per retired instruction.
REQ-037 ir_write SHALL be asserted exactly once per fetch.
REQ-038 Outputs SHALL be combinational from the state register plus opcode, branch_taken and mem_ready; there SHALL be no combinational path from opcode to state.

Reset
REQ-039 While rst_n=0 the block SHALL be in FETCH with the timeout counter=0, fault=0, and all enables and mem_req low.
REQ-040 The first mem_req SHALL be asserted in the first cycle after rst_n deasserts.
REQ-041 Reset asserted mid-transfer SHALL drop mem_req immediately, and any pending write SHALL be abandoned.

Structure
REQ-042 State encoding, opcode constants, and the pcsrc and wb_sel encodings SHALL live in shared package ctrl_pkg, also used by the PC next-value mux and the datapath.
REQ-043 Opcode classification (legal, is_load, is_store, is_branch, is_jal, is_jalr, is_fence) SHALL be one sub-module, ctrl_decode.

Verification
REQ-044 ADD with zero-wait memory -> FETCH, DECODE, EXEC, WB in 4 cycles; WB has reg_write=1, wb_sel=00, pc_write=1, pcsrc=00.
REQ-045 BEQ with branch_taken=1, then with branch_taken=0 -> EXEC pc_write=1 with pcsrc=01, then pcsrc=00; reg_write never 1.
REQ-046 LW with mem_ready delayed 3 cycles in MEM -> mem_req=1, mem_we=0, addr_sel=1 held 4 cycles, then WB with wb_sel=01; 8 cycles total.
REQ-047 JALR -> WB has wb_sel=10, pcsrc=11; JAL -> pcsrc=10.
REQ-048 TMO_W=4 and mem_ready held 0 in FETCH -> FAULT after 15 cycles with fault=1; opcode 1110011 -> FAULT from DECODE.
REQ-049 rst_n pulsed low during a store's MEM state -> mem_req=0 asynchronously, state=FETCH, fault=0.
